tremolo_modulator: RTL and testbench

Audio-rate amplitude modulator for the tremolo effect. It consumes the 16-bit unsigned triangle LFO value produced by the triangle generator and scales each incoming signed audio sample by an LFO-derived gain. Modulation depth is user-set and slewed per sample to avoid zipper noise. It sits between the codec-side sample source and the output mixer, and exposes a 3-stage, fully pipelined valid-strobe interface.

---
 rtl/tremolo_modulator.sv | 138 +++++++++++++
 tb/tb_tremolo_modulator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tremolo_modulator.sv
// tremolo_modulator: scales signed audio samples by a gain derived from a
// triangle LFO level and a slewed modulation depth.
//
// Handshake: there is no ready. sample_in is taken on every rising edge where
// sample_in_valid is 1. The result appears with a one-cycle sample_out_valid
// strobe exactly three edges after the accepting edge. Outputs come back in
// input order, and sample_out holds its value between strobes.
module tremolo_modulator #(
  parameter int DEPTH_MAX = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] lfo_val,
  input  logic [4:0]  depth,
  input  logic        enable,
  input  logic [15:0] sample_in,
  input  logic        sample_in_valid,
  output logic [15:0] sample_out,
  output logic        sample_out_valid,
  output logic [4:0]  depth_eff
);

  localparam logic [4:0] DEPTH_FULL = 5'(DEPTH_MAX);

  // Depth target after saturating out-of-range codes to full scale.
  logic [4:0] depth_tgt;

  // Stage 1: captured inputs plus the depth this sample is scaled with.
  logic        s1_valid;
  logic [15:0] s1_sample;
  logic        s1_enable;
  logic [15:0] s1_lfo;
  logic [4:0]  s1_depth;

  // Stage 2: gain ready for the multiplier.
  logic        s2_valid;
  logic [15:0] s2_sample;
  logic        s2_enable;
  logic [15:0] s2_gain;

  // Stage 3: full-precision product.
  logic               s3_valid;
  logic [15:0]        s3_sample;
  logic               s3_enable;
  logic signed [32:0] s3_product;

  // Gain arithmetic. The depth is at most 16, so the 21-bit product shifted
  // right by 4 never exceeds 0xFFFF and the subtraction cannot wrap.
  logic [15:0] lfo_inv;
  logic [20:0] scaled;

  // Saturate the requested depth and form the attenuation term.
  always_comb begin
    depth_tgt = (depth > DEPTH_FULL) ? DEPTH_FULL : depth;
    lfo_inv   = 16'hFFFF - s1_lfo;
    scaled    = 21'(lfo_inv) * 21'(s1_depth);
  end

  // Depth slew: one step toward the target per accepted sample only.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      depth_eff <= 5'd0;
    end else if (sample_in_valid) begin
      if (depth_eff < depth_tgt) begin
        depth_eff <= depth_eff + 5'd1;
      end else if (depth_eff > depth_tgt) begin
        depth_eff <= depth_eff - 5'd1;
      end
    end
  end

  // Stage 1 capture; the depth snapshot is the value before this edge's step.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid  <= 1'b0;
      s1_sample <= 16'h0000;
      s1_enable <= 1'b0;
      s1_lfo    <= 16'h0000;
      s1_depth  <= 5'd0;
    end else begin
      s1_valid <= sample_in_valid;
      if (sample_in_valid) begin
        s1_sample <= sample_in;
        s1_enable <= enable;
        s1_lfo    <= lfo_val;
        s1_depth  <= depth_eff;
      end
    end
  end

  // Stage 2: register the gain 0xFFFF - ((0xFFFF - lfo) * depth >> 4).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s2_valid  <= 1'b0;
      s2_sample <= 16'h0000;
      s2_enable <= 1'b0;
      s2_gain   <= 16'h0000;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sample <= s1_sample;
        s2_enable <= s1_enable;
        s2_gain   <= 16'hFFFF - 16'(scaled >> 4);
      end
    end
  end

  // Stage 3: signed sample times zero-extended (non-negative) gain.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s3_valid   <= 1'b0;
      s3_sample  <= 16'h0000;
      s3_enable  <= 1'b0;
      s3_product <= 33'sd0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_sample  <= s2_sample;
        s3_enable  <= s2_enable;
        s3_product <= 33'($signed(s2_sample)) * 33'($signed({1'b0, s2_gain}));
      end
    end
  end

  // Output: arithmetic floor of product / 65536, or the raw sample in bypass.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sample_out       <= 16'h0000;
      sample_out_valid <= 1'b0;
    end else begin
      sample_out_valid <= s3_valid;
      if (s3_valid) begin
        sample_out <= s3_enable ? 16'(s3_product >>> 16) : s3_sample;
      end
    end
  end

endmodule

// File: tb/tb_tremolo_modulator.sv
// tb_tremolo_modulator: directed vectors with hand-computed results for the
// tremolo modulator, plus sequences for depth slew, bypass and reset.
module tb_tremolo_modulator;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] lfo_val;
  logic [4:0]  depth;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_in_valid;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic [4:0]  depth_eff;

  tremolo_modulator #(.DEPTH_MAX(16)) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .lfo_val          (lfo_val),
    .depth            (depth),
    .enable           (enable),
    .sample_in        (sample_in),
    .sample_in_valid  (sample_in_valid),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .depth_eff        (depth_eff)
  );

  // Clock and edge counter
  always #5 CLK = ~CLK;

  int pcyc = 0;
  always @(posedge CLK) pcyc <= pcyc + 1;

  // Scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  int          ts_q[$];
  logic [15:0] last_out = 16'h0000;
  logic [15:0] mon_exp;
  int          mon_ts;

  typedef struct {
    logic [15:0] sample;
    logic [15:0] lfo;
    logic [4:0]  depth;
    logic        en;
    logic [15:0] exp_out;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Driver: present one sample at a falling edge; the next rising edge accepts
  // it, and the output strobe is seen at the falling edge after three more.
  task automatic send(input logic [15:0] s, input logic [15:0] l, input logic [4:0] d,
                      input logic en, input logic [15:0] e);
    @(negedge CLK);
    sample_in       = s;
    lfo_val         = l;
    depth           = d;
    enable          = en;
    sample_in_valid = 1'b1;
    exp_q.push_back(e);
    ts_q.push_back(pcyc + 4);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      sample_in_valid = 1'b0;
    end
  endtask

  // Monitor: every strobe must match the head of the queue at its exact cycle,
  // and sample_out must hold between strobes.
  always @(negedge CLK) begin
    if (!RESET_N) begin
      last_out = 16'h0000;
    end else if (sample_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got sample_out_valid=1 (%0h), expected no strobe (t=%0t)",
                 sample_out, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_ts  = ts_q.pop_front();
        check("sample_out", 32'(sample_out), 32'(mon_exp));
        check("latency_cycle", pcyc, mon_ts);
      end
      last_out = sample_out;
    end else begin
      check("hold", 32'(sample_out), 32'(last_out));
    end
  end

  initial begin
    // Steady-state vectors with depth_eff settled at 16
    tbl[0] = '{16'h4000, 16'h8000, 5'd16, 1'b1, 16'h2000}; // gain 0x8000
    tbl[1] = '{16'h7FFF, 16'h0000, 5'd16, 1'b1, 16'h0000}; // gain 0
    tbl[2] = '{16'h8000, 16'h0000, 5'd16, 1'b1, 16'h0000}; // gain 0: product exactly 0
    tbl[3] = '{16'h8000, 16'hFFFF, 5'd16, 1'b1, 16'h8000}; // floor(-32767.5)
    tbl[4] = '{16'hFFFF, 16'h0010, 5'd16, 1'b1, 16'hFFFF}; // gain 0x10: -16 floors to -1
    tbl[5] = '{16'h7FFF, 16'hFFFF, 5'd16, 1'b1, 16'h7FFE}; // 0x7FFE8001 >> 16
    tbl[6] = '{16'h4000, 16'h8000, 5'd16, 1'b0, 16'h4000}; // bypass
    tbl[7] = '{16'hC000, 16'h8000, 5'd16, 1'b1, 16'hE000}; // -16384 * 0.5

    RESET_N         = 1'b0;
    lfo_val         = 16'h0000;
    depth           = 5'd0;
    enable          = 1'b0;
    sample_in       = 16'h0000;
    sample_in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RESET_N = 1'b1;

    // Reset values
    @(negedge CLK);
    check("reset_sample_out", 32'(sample_out), 32'h0);
    check("reset_valid", 32'(sample_out_valid), 32'h0);
    check("reset_depth_eff", 32'(depth_eff), 32'h0);

    // First sample: depth_eff 0 gives unity gain regardless of lfo
    send(16'h4000, 16'h0000, 5'd0, 1'b1, 16'h3FFF);
    idle(1);
    check("first_depth_eff", 32'(depth_eff), 32'h0);
    idle(5);

    // Slew up with saturated depth code, strobe every 4 cycles
    for (int i = 0; i < 18; i++) begin
      send(16'h0000, 16'hFFFF, 5'd31, 1'b1, 16'h0000);
      idle(1);
      check("slew_up", 32'(depth_eff), (i < 16) ? 32'(i + 1) : 32'd16);
      idle(2);
    end
    depth = 5'd0;
    idle(3);
    check("no_strobe_no_slew", 32'(depth_eff), 32'd16);

    // Table vectors, back-to-back
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].sample, tbl[i].lfo, tbl[i].depth, tbl[i].en, tbl[i].exp_out);
    end
    idle(6);
    check("table_depth_eff", 32'(depth_eff), 32'd16);

    // Slew down to 8
    for (int i = 0; i < 8; i++) begin
      send(16'h0000, 16'hFFFF, 5'd8, 1'b1, 16'h0000);
      idle(1);
      check("slew_down", 32'(depth_eff), 32'(15 - i));
      idle(2);
    end
    // depth_eff 8, lfo 0: (0xFFFF*8)>>4 = 0x7FFF, gain 0x8000
    send(16'h4000, 16'h0000, 5'd8, 1'b1, 16'h2000);
    // Depth change with strobe: old depth_eff 8 used, then steps to 9
    send(16'h4000, 16'h0000, 5'd16, 1'b1, 16'h2000);
    idle(1);
    check("simul_depth_step", 32'(depth_eff), 32'd9);
    idle(5);

    // Bypass, four consecutive strobes
    send(16'h1234, 16'h0000, 5'd16, 1'b0, 16'h1234);
    send(16'h8001, 16'h0000, 5'd16, 1'b0, 16'h8001);
    send(16'h7FFF, 16'h0000, 5'd16, 1'b0, 16'h7FFF);
    send(16'h0001, 16'h0000, 5'd16, 1'b0, 16'h0001);
    idle(6);
    check("bypass_depth_eff", 32'(depth_eff), 32'd13);

    // Asynchronous reset with two samples in flight
    send(16'h1111, 16'h0000, 5'd16, 1'b1, 16'h0000);
    send(16'h2222, 16'h0000, 5'd16, 1'b1, 16'h0000);
    @(posedge CLK);
    #2;
    RESET_N         = 1'b0;
    sample_in_valid = 1'b0;
    #1;
    check("async_sample_out", 32'(sample_out), 32'h0);
    check("async_valid", 32'(sample_out_valid), 32'h0);
    check("async_depth_eff", 32'(depth_eff), 32'h0);
    exp_q.delete();
    ts_q.delete();
    repeat (2) @(negedge CLK);
    #2 RESET_N = 1'b1;
    idle(5);

    // First sample after release is unmodulated again
    send(16'h4000, 16'h0000, 5'd16, 1'b1, 16'h3FFF);
    idle(1);
    check("post_reset_depth_eff", 32'(depth_eff), 32'd1);
    idle(6);

    check("drain_queue", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
